// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub for the OTTER IOBUS: input ports, strobed output registers, IRQ pending/mask.
// Define MMIO_READBACK_EN to make output slots readable; otherwise they read as zero.
module otter_mmio_hub #(
    parameter logic [31:0] BASE_AD     = 32'h11000000,
    parameter int          STRIDE_LOG2 = 18,
    parameter int          N_IN        = 4,
    parameter int          N_OUT       = 4,
    parameter int          N_IRQ       = 2,
    parameter int          DW          = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    input  logic [N_IN*DW-1:0]    IN_DATA,
    output logic [N_OUT*DW-1:0]   OUT_DATA,
    output logic [N_OUT-1:0]      OUT_STB,
    input  logic [N_IRQ-1:0]      IRQ_SRC,
    output logic                  INTR
);

    localparam logic [31:0] LOW_MASK  = (32'd1 << STRIDE_LOG2) - 32'd1;
    localparam logic [31:0] PEND_SLOT = 32'(N_IN + N_OUT);
    localparam logic [31:0] MASK_SLOT = 32'(N_IN + N_OUT + 1);

    logic [DW-1:0]    in_q [N_IN];
    logic [N_IRQ-1:0] irq_sync_p0;
    logic [N_IRQ-1:0] irq_sync_p1;
    logic [N_IRQ-1:0] irq_prev_p2;
    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] pend_clr;
    logic             mask_wr;
    logic [N_OUT-1:0] out_wr;

    // The 33-bit subtract flags addresses below BASE_AD so they cannot alias onto high slots.
    logic [32:0] off_full;
    logic [31:0] slot;
    logic        hit;

    assign off_full = {1'b0, IOBUS_ADDR} - {1'b0, BASE_AD};
    assign slot     = off_full[31:0] >> STRIDE_LOG2;
    assign hit      = !off_full[32] && ((off_full[31:0] & LOW_MASK) == 32'd0) && (slot <= MASK_SLOT);

    always_comb begin
        out_wr = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_wr[k] = IOBUS_WR && hit && (slot == 32'(N_IN + k));
        end
    end

    assign pend_clr = (IOBUS_WR && hit && (slot == PEND_SLOT)) ? IOBUS_OUT[N_IRQ-1:0] : '0;
    assign mask_wr  = IOBUS_WR && hit && (slot == MASK_SLOT);
    assign irq_rise = irq_sync_p1 & ~irq_prev_p2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < N_IN; k++) begin
                in_q[k] <= '0;
            end
            OUT_DATA    <= '0;
            OUT_STB     <= '0;
            irq_sync_p0 <= '0;
            irq_sync_p1 <= '0;
            irq_prev_p2 <= '0;
            pend        <= '0;
            mask        <= '0;
            INTR        <= 1'b0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                in_q[k] <= IN_DATA[k*DW +: DW];
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (out_wr[k]) begin
                    OUT_DATA[k*DW +: DW] <= IOBUS_OUT[DW-1:0];
                end
            end
            OUT_STB <= out_wr;
            // synchroniser stages, then the previous-value flop for edge detection
            irq_sync_p0 <= IRQ_SRC;
            irq_sync_p1 <= irq_sync_p0;
            irq_prev_p2 <= irq_sync_p1;
            // a fresh edge beats a simultaneous write-1-to-clear
            pend <= (pend & ~pend_clr) | irq_rise;
            if (mask_wr) begin
                mask <= IOBUS_OUT[N_IRQ-1:0];
            end
            INTR <= |(pend & mask);
        end
    end

    always_comb begin
        IOBUS_IN = 32'h0;
        if (hit) begin
            for (int k = 0; k < N_IN; k++) begin
                if (slot == 32'(k)) begin
                    IOBUS_IN = 32'(in_q[k]);
                end
            end
`ifdef MMIO_READBACK_EN
            for (int k = 0; k < N_OUT; k++) begin
                if (slot == 32'(N_IN + k)) begin
                    IOBUS_IN = 32'(OUT_DATA[k*DW +: DW]);
                end
            end
`else
`endif
            if (slot == PEND_SLOT) begin
                IOBUS_IN = 32'(pend);
            end
            if (slot == MASK_SLOT) begin
                IOBUS_IN = 32'(mask);
            end
        end
    end

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Directed bench for otter_mmio_hub at default parameters (4 in, 4 out, 2 IRQ, 32-bit ports).
module tb_otter_mmio_hub;

    localparam logic [31:0] A_IN0  = 32'h11000000;
    localparam logic [31:0] A_IN2  = 32'h11080000;
    localparam logic [31:0] A_OUT0 = 32'h11100000;
    localparam logic [31:0] A_OUT1 = 32'h11140000;
    localparam logic [31:0] A_OUT2 = 32'h11180000;
    localparam logic [31:0] A_PEND = 32'h11200000;
    localparam logic [31:0] A_MASK = 32'h11240000;
    localparam logic [31:0] A_NONE = 32'h11280000;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  IOBUS_ADDR;
    logic [31:0]  IOBUS_OUT;
    logic         IOBUS_WR;
    logic [31:0]  IOBUS_IN;
    logic [127:0] IN_DATA;
    logic [127:0] OUT_DATA;
    logic [3:0]   OUT_STB;
    logic [1:0]   IRQ_SRC;
    logic         INTR;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rb_exp;

    otter_mmio_hub dut (
        .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
        .OUT_STB(OUT_STB), .IRQ_SRC(IRQ_SRC), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        IOBUS_ADDR = a;
        #1;
    endtask

    initial begin
        RESET = 1'b1; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
        IN_DATA = '0; IRQ_SRC = '0;
        tick();
        RESET = 1'b0;
        check("rst_out_data", OUT_DATA[31:0] | OUT_DATA[63:32] | OUT_DATA[95:64] | OUT_DATA[127:96], 32'h0);
        check("rst_out_stb", 32'(OUT_STB), 32'h0);
        check("rst_intr", 32'(INTR), 32'h0);
        rd(A_PEND); check("rst_pend", IOBUS_IN, 32'h0);
        rd(A_MASK); check("rst_mask", IOBUS_IN, 32'h0);

        // single write to output port 0
        IOBUS_ADDR = A_OUT0; IOBUS_OUT = 32'h0000A5A5; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        check("wr0_data", OUT_DATA[31:0], 32'h0000A5A5);
        check("wr0_stb", 32'(OUT_STB), 32'h1);
        tick();
        check("wr0_stb_gone", 32'(OUT_STB), 32'h0);

        // misaligned write ignored
        IOBUS_ADDR = A_OUT0 + 32'd4; IOBUS_OUT = 32'hFFFFFFFF; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        check("misal_wr_data", OUT_DATA[31:0], 32'h0000A5A5);
        check("misal_wr_stb", 32'(OUT_STB), 32'h0);

        // input port 2 read with one cycle of staleness
        IN_DATA[64 +: 32] = 32'hDEADBEEF;
        rd(A_IN2); check("in2_stale", IOBUS_IN, 32'h0);
        tick();
        check("in2_read", IOBUS_IN, 32'hDEADBEEF);
        rd(A_IN2 + 32'd4); check("in2_misal", IOBUS_IN, 32'h0);
        rd(A_NONE); check("unmapped_rd", IOBUS_IN, 32'h0);
        rd(32'h10FC0000); check("below_base_rd", IOBUS_IN, 32'h0);
        rd(A_IN0); check("in0_read", IOBUS_IN, 32'h0);

        // back-to-back writes to output port 1
        IOBUS_ADDR = A_OUT1; IOBUS_OUT = 32'h11; IOBUS_WR = 1'b1;
        tick();
        check("b2b_stb1", 32'(OUT_STB), 32'h2);
        check("b2b_data1", OUT_DATA[63:32], 32'h11);
        IOBUS_OUT = 32'h22;
        tick();
        IOBUS_WR = 1'b0;
        check("b2b_stb2", 32'(OUT_STB), 32'h2);
        check("b2b_data2", OUT_DATA[63:32], 32'h22);
        tick();
        check("b2b_stb_end", 32'(OUT_STB), 32'h0);

        // reset coinciding with a write
        IOBUS_ADDR = A_OUT2; IOBUS_OUT = 32'h77; IOBUS_WR = 1'b1; RESET = 1'b1;
        tick();
        RESET = 1'b0; IOBUS_WR = 1'b0;
        check("rstwr_stb", 32'(OUT_STB), 32'h0);
        check("rstwr_out2", OUT_DATA[95:64], 32'h0);
        check("rstwr_out0", OUT_DATA[31:0], 32'h0);
        rd(A_IN2); check("rst_in_q", IOBUS_IN, 32'h0);

        // mask bit 0, pulse source 0
        IOBUS_ADDR = A_MASK; IOBUS_OUT = 32'h1; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        rd(A_MASK); check("mask_read", IOBUS_IN, 32'h1);
        IRQ_SRC = 2'b01;
        rd(A_PEND);
        tick();
        IRQ_SRC = 2'b00;
        check("irq0_e1", IOBUS_IN, 32'h0);
        tick();
        check("irq0_e2", IOBUS_IN, 32'h0);
        tick();
        check("irq0_e3_pend", IOBUS_IN, 32'h1);
        check("irq0_e3_intr", 32'(INTR), 32'h0);
        tick();
        check("irq0_e4_intr", 32'(INTR), 32'h1);

        // write-1-to-clear
        IOBUS_OUT = 32'h1; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        check("w1c_pend", IOBUS_IN, 32'h0);
        tick();
        check("w1c_intr", 32'(INTR), 32'h0);

        // masked source 1
        IRQ_SRC = 2'b10;
        tick();
        IRQ_SRC = 2'b00;
        tick();
        tick();
        check("irq1_pend", IOBUS_IN, 32'h2);
        tick();
        check("irq1_intr_masked", 32'(INTR), 32'h0);

        // rising edge of source 0 lands in the same cycle as a clear of bit 0
        IRQ_SRC = 2'b01;
        tick();
        tick();
        IOBUS_OUT = 32'h1; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        check("set_wins", IOBUS_IN, 32'h3);

        // level still high: once cleared, bit 0 stays clear
        IOBUS_OUT = 32'h1; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        tick();
        tick();
        tick();
        check("level_no_reset", IOBUS_IN, 32'h2);
        IRQ_SRC = 2'b00;

        // readback of output port 1
        IOBUS_ADDR = A_OUT1; IOBUS_OUT = 32'h1234; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        check("rb_out_data", OUT_DATA[63:32], 32'h1234);
`ifdef MMIO_READBACK_EN
        rb_exp = 32'h1234;
`else
        rb_exp = 32'h0;
`endif
        rd(A_OUT1); check("readback", IOBUS_IN, rb_exp);

        // write to unmapped slot touches nothing
        IOBUS_ADDR = A_NONE; IOBUS_OUT = 32'hFFFFFFFF; IOBUS_WR = 1'b1;
        tick();
        IOBUS_WR = 1'b0;
        check("unmapped_wr_stb", 32'(OUT_STB), 32'h0);
        check("unmapped_wr_out1", OUT_DATA[63:32], 32'h1234);
        rd(A_MASK); check("unmapped_wr_mask", IOBUS_IN, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
